// File: rtl/sub16_serial_if.sv
// Start/busy/done handshake bundle for the nibble-serial subtractor.
// The requester drives operands and start; the subtractor returns status, difference and flags.
interface sub16_serial_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport master (
      output start, a, b, bin,
      input  busy, done, d, bout, ovf, zero
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, d, bout, ovf, zero
   );
endinterface

// File: rtl/sub16_serial.sv
// Nibble-serial subtractor: d = a - b - bin over WIDTH/4 cycles through one
// registered 4-bit add-of-complement stage, with borrow, overflow and zero flags.
module sub16_serial #(
   parameter int unsigned WIDTH = 16
) (
   input logic            clk,
   input logic            rst,
   sub16_serial_if.slave  bus
);
   localparam int unsigned SW   = 4;
   localparam int unsigned N    = WIDTH / SW;
   localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_n;
   logic [IDXW-1:0]   idx_q,   idx_n;
   logic              c_q,     c_n;
   logic [WIDTH-1:0]  a_q,     a_n;
   logic [WIDTH-1:0]  b_q,     b_n;
   logic [WIDTH-1:0]  d_q,     d_n;
   logic              busy_q,  busy_n;
   logic              done_q,  done_n;
   logic              bout_q,  bout_n;
   logic              ovf_q,   ovf_n;
   logic              zero_q,  zero_n;

   logic [SW-1:0]     a_sl;
   logic [SW-1:0]     b_sl;
   logic [SW:0]       sum;
   logic [WIDTH-1:0]  d_wr;
   logic              last;

   // 4-bit carry-lookahead add: per-bit generate/propagate, returns {carry_out, sum}
   function automatic logic [SW:0] add4(input logic [SW-1:0] x,
                                        input logic [SW-1:0] y,
                                        input logic          cin);
      logic [SW-1:0] g;
      logic [SW-1:0] p;
      logic [SW:0]   c;
      g    = x & y;
      p    = x ^ y;
      c[0] = cin;
      for (int unsigned i = 0; i < SW; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return {c[SW], p ^ c[SW-1:0]};
   endfunction

   // Slice selection, slice add and the difference with the current slice merged in
   always_comb begin
      a_sl = a_q[SW-1:0];
      b_sl = b_q[SW-1:0];
      for (int unsigned i = 0; i < N; i++) begin
         if (idx_q == IDXW'(i)) begin
            a_sl = a_q[SW*i +: SW];
            b_sl = b_q[SW*i +: SW];
         end
      end
      sum  = add4(a_sl, ~b_sl, c_q);
      d_wr = d_q;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx_q == IDXW'(i)) begin
            d_wr[SW*i +: SW] = sum[SW-1:0];
         end
      end
      last = (idx_q == IDXW'(N - 1));
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      c_n     = c_q;
      a_n     = a_q;
      b_n     = b_q;
      d_n     = d_q;
      busy_n  = busy_q;
      done_n  = 1'b0;
      bout_n  = bout_q;
      ovf_n   = ovf_q;
      zero_n  = zero_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_n     = bus.a;
               b_n     = bus.b;
               c_n     = ~bus.bin;
               idx_n   = '0;
               busy_n  = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            d_n   = d_wr;
            c_n   = sum[SW];
            idx_n = idx_q + IDXW'(1);
            if (last) begin
               // borrow is the inverted carry of the complement add
               bout_n  = ~sum[SW];
               ovf_n   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[SW-1] != a_q[WIDTH-1]);
               zero_n  = (d_wr == '0);
               done_n  = 1'b1;
               busy_n  = 1'b0;
               idx_n   = '0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            idx_n   = '0;
         end
      endcase
   end

   // State and output registers; reset also aborts an operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         c_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         c_q     <= c_n;
         a_q     <= a_n;
         b_q     <= b_n;
         d_q     <= d_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
         bout_q  <= bout_n;
         ovf_q   <= ovf_n;
         zero_q  <= zero_n;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.d    = d_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial: the driver pushes arithmetic-model results,
// the monitor pops and compares on every done pulse, including latency.
module tb_sub16_serial;
   localparam int unsigned W = 16;
   localparam int unsigned N = W / 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sub16_serial_if #(.WIDTH(W)) bus ();
   sub16_serial #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [15:0] d;
      logic        bout;
      logic        ovf;
      logic        zero;
      logic [31:0] due;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Plain integer arithmetic reference: unsigned result/borrow and signed range test
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
      exp_t r;
      int   full;
      int   sfull;
      full   = int'(a) - int'(b) - int'(bin);
      sfull  = int'($signed(a)) - int'($signed(b)) - int'(bin);
      r.d    = 16'(full);
      r.bout = (full < 0);
      r.ovf  = (sfull > 32767) || (sfull < -32768);
      r.zero = (16'(full) == 16'h0000);
      r.due  = '0;
      return r;
   endfunction

   // Monitor: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         chk("done_width", 32'(prev_done), 32'd0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("latency", cyc, mon_e.due);
            chk("d", 32'(bus.d), 32'(mon_e.d));
            chk("bout", 32'(bus.bout), 32'(mon_e.bout));
            chk("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
            chk("zero", 32'(bus.zero), 32'(mon_e.zero));
         end
      end
      prev_done = bus.done;
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) chk("issue_timeout", 32'(bus.busy), 32'd0);
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      e     = model(a, b, bin);
      e.due = cyc + N;
      sb.push_back(e);
      bus.start = 1'b0;
      // operands changing after acceptance must not matter
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      bus.bin   = 1'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || bus.busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_d"},    32'(bus.d),    32'd0);
      chk({tag, "_bout"}, 32'(bus.bout), 32'd0);
      chk({tag, "_ovf"},  32'(bus.ovf),  32'd0);
      chk({tag, "_zero"}, 32'(bus.zero), 32'd0);
   endtask

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
   } op_t;

   op_t dir[6];

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // First operation with explicit cycle-by-cycle handshake checks
      issue(16'h1234, 16'h0234, 1'b0);
      for (int k = 0; k < int'(N); k++) begin
         @(negedge clk);
         chk("t1_busy", 32'(bus.busy), 32'd1);
         chk("t1_done_early", 32'(bus.done), 32'd0);
      end
      @(negedge clk);
      chk("t1_done", 32'(bus.done), 32'd1);
      chk("t1_busy_low", 32'(bus.busy), 32'd0);
      chk("t1_d_const", 32'(bus.d), 32'h1000);

      // Boundary operands
      dir[0] = '{16'h0000, 16'h0001, 1'b0};
      dir[1] = '{16'h8000, 16'h0001, 1'b0};
      dir[2] = '{16'h7FFF, 16'hFFFF, 1'b0};
      dir[3] = '{16'h0010, 16'h000F, 1'b1};
      dir[4] = '{16'h5A5A, 16'h5A5A, 1'b0};
      dir[5] = '{16'h0000, 16'h0000, 1'b1};
      for (int i = 0; i < 6; i++) issue(dir[i].a, dir[i].b, dir[i].bin);
      wait_idle();

      // Start pulse with new operands during busy is ignored
      issue(16'h1111, 16'h0111, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 16'hFFFF;
      bus.b     = 16'h0000;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();

      // Back-to-back: second start lands in the done cycle of the first
      issue(16'h8000, 16'h0001, 1'b0);
      issue(16'h0003, 16'h0005, 1'b0);
      wait_idle();
      chk("b2b_d_const", 32'(bus.d), 32'hFFFE);
      chk("b2b_bout_const", 32'(bus.bout), 32'd1);

      // Reset in the second RUN cycle aborts without done
      issue(16'hABCD, 16'h1234, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("midrst");
      sb.delete();
      rst = 1'b0;
      repeat (N + 2) @(negedge clk);
      chk("midrst_idle", 32'(bus.busy), 32'd0);

      // Reset together with start: not accepted
      @(negedge clk);
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = 16'h4321;
      bus.b     = 16'h0021;
      @(negedge clk);
      chk("rststart_busy", 32'(bus.busy), 32'd0);
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk("rststart_busy_after", 32'(bus.busy), 32'd0);
      repeat (N + 2) @(negedge clk);
      chk("rststart_d", 32'(bus.d), 32'd0);

      // Randomized sustained traffic
      for (int i = 0; i < 10000; i++) begin
         issue(16'($urandom), 16'($urandom), 1'($urandom));
      end
      wait_idle();
      repeat (N + 3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
